point_unpacker: RTL and testbench



---
 rtl/point_unpacker_if.sv | 29 ++
 rtl/point_unpacker.sv | 154 +++++++++++++++
 tb/tb_point_unpacker.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/point_unpacker_if.sv
// Word-in / point-out bus of the point unpacker: one-shot packed word strobe
// in, one-point-per-handshake valid/ready stream plus FIFO status out.
interface point_unpacker_if #(
  parameter int POINTS_PER_WORD = 4,
  parameter int POINT_W         = 128,
  parameter int FIFO_DEPTH      = 2
);
  localparam int WORD_W = POINTS_PER_WORD * POINT_W;
  localparam int LW     = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_W-1:0]  packed_data;
  logic               packed_valid;
  logic [POINT_W-1:0] point_data;
  logic               point_valid;
  logic               point_ready;
  logic               point_last;
  logic               overflow;
  logic [LW-1:0]      fifo_level;

  modport master (
    output packed_data, packed_valid, point_ready,
    input  point_data, point_valid, point_last, overflow, fifo_level
  );

  modport slave (
    input  packed_data, packed_valid, point_ready,
    output point_data, point_valid, point_last, overflow, fifo_level
  );
endinterface

// File: rtl/point_unpacker.sv
// Buffers packed point-cloud words in a small FIFO and streams their points
// one lane per handshake. Optional drop counter: define UNPACK_DROP_CNT_EN.
//
// state    | meaning
// S_IDLE   | word FIFO empty, point_valid low
// S_STREAM | head word present, lane idx_q presented on point_data
module point_unpacker #(
  parameter int POINTS_PER_WORD = 4,
  parameter int POINT_W         = 128,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic            clk,
  input  logic            reset,
  point_unpacker_if.slave bus
`ifdef UNPACK_DROP_CNT_EN
  ,
  output logic [15:0]     drop_count
`endif
);
  localparam int WORD_W = POINTS_PER_WORD * POINT_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = $clog2(FIFO_DEPTH) + 1;
  localparam int IW     = (POINTS_PER_WORD > 1) ? $clog2(POINTS_PER_WORD) : 1;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               overflow_q, overflow_d;

  logic [WORD_W-1:0]  mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0]  head_word;
  logic [POINT_W-1:0] lanes [POINTS_PER_WORD];

  logic full;
  logic streaming;
  logic handshake;
  logic last_lane;
  logic retire;
  logic wr_en;
  logic drop;

  always_comb begin
    full      = (level_q == LW'(FIFO_DEPTH));
    streaming = (state_q == S_STREAM);
    handshake = streaming && bus.point_ready;
    last_lane = (idx_q == IW'(POINTS_PER_WORD - 1));
    retire    = handshake && last_lane;
    // a full FIFO still accepts a word when the head retires in the same cycle
    wr_en     = bus.packed_valid && (!full || retire);
    drop      = bus.packed_valid && full && !retire;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    idx_d      = idx_q;
    overflow_d = drop;

    if (handshake) begin
      idx_d = last_lane ? '0 : idx_q + 1'b1;
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (retire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({wr_en, retire})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (retire && !wr_en && (level_q == LW'(1))) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; the pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[wr_ptr_q] <= bus.packed_data;
    end
  end

  assign head_word = mem_q[rd_ptr_q];

  for (genvar k = 0; k < POINTS_PER_WORD; k++) begin : g_lane
    assign lanes[k] = head_word[k*POINT_W +: POINT_W];
  end

  assign bus.point_valid = streaming;
  assign bus.point_data  = streaming ? lanes[idx_q] : '0;
  assign bus.point_last  = streaming && last_lane;
  assign bus.overflow    = overflow_q;
  assign bus.fifo_level  = level_q;

`ifdef UNPACK_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_point_unpacker.sv
// Bench for point_unpacker: directed cycle table, then random traffic
// against a queue-based word model.
module tb_point_unpacker;
  localparam int P  = 4;
  localparam int PW = 128;
  localparam int D  = 2;
  localparam int WW = P * PW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  point_unpacker_if #(.POINTS_PER_WORD(P), .POINT_W(PW), .FIFO_DEPTH(D)) bus ();

`ifdef UNPACK_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  point_unpacker #(.POINTS_PER_WORD(P), .POINT_W(PW), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef UNPACK_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // lane k of word w carries the nibble (w*4+k+1) repeated across 128 bits
  function automatic logic [PW-1:0] pat(input int pt);
    logic [3:0] nib;
    nib = 4'(pt);
    return (pt == 0) ? '0 : {32{nib}};
  endfunction

  function automatic logic [WW-1:0] mk_word(input int w);
    logic [WW-1:0] word;
    for (int k = 0; k < P; k++) word[k*PW +: PW] = pat(w * P + k + 1);
    return word;
  endfunction

  typedef struct {
    logic rst;
    logic pv;
    int   w;
    logic rdy;
    int   ept;   // expected lane tag after the edge, 0 = not valid
    logic el;
    logic eo;
    int   elvl;
    int   edc;
  } vec_t;

  vec_t tbl[$];
  int   dc_fill = 0;

  function automatic void add(input logic rst, input logic pv, input int w, input logic rdy,
                              input int ept, input logic el, input logic eo, input int elvl);
    vec_t v;
    v.rst = rst; v.pv = pv; v.w = w; v.rdy = rdy;
    v.ept = ept; v.el = el; v.eo = eo; v.elvl = elvl; v.edc = dc_fill;
    tbl.push_back(v);
  endfunction

  // behavioural model state
  logic [WW-1:0] mq[$];
  int            midx;
  logic          movf;
  int            mdc;

  task automatic model_step(input logic rst, input logic pv, input logic [WW-1:0] word,
                            input logic rdy);
    bit full, hs, ret;
    if (rst) begin
      mq.delete(); midx = 0; movf = 1'b0; mdc = 0;
      return;
    end
    full = (mq.size() == D);
    hs   = (mq.size() > 0) && rdy;
    ret  = hs && (midx == P - 1);
    movf = 1'b0;
    if (hs) begin
      if (ret) begin
        midx = 0;
        void'(mq.pop_front());
      end else begin
        midx++;
      end
    end
    if (pv) begin
      if (!full || ret) mq.push_back(word);
      else begin
        movf = 1'b1;
        if (mdc < 65535) mdc++;
      end
    end
  endtask

  initial begin
    logic [WW-1:0] rw;
    logic [WW-1:0] hw;
    logic [PW-1:0] edata;
    logic          rrst, rpv, rrdy;
    int            pv_pct;

    reset = 1'b1;
    bus.packed_valid = 1'b0;
    bus.packed_data  = '0;
    bus.point_ready  = 1'b0;

    // reset
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    // single word, ready high
    add(0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 2, 0, 0, 1);
    add(0, 0, 0, 1, 3, 0, 0, 1);
    add(0, 0, 0, 1, 4, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // two words four cycles apart, no bubble
    add(0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 2, 0, 0, 1);
    add(0, 0, 0, 1, 3, 0, 0, 1);
    add(0, 0, 0, 1, 4, 1, 0, 1);
    add(0, 1, 1, 1, 5, 0, 0, 1);
    add(0, 0, 0, 1, 6, 0, 0, 1);
    add(0, 0, 0, 1, 7, 0, 0, 1);
    add(0, 0, 0, 1, 8, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // ready toggling 1,0,0,1,1,0,1
    add(0, 1, 2, 0, 9, 0, 0, 1);
    add(0, 0, 0, 1, 10, 0, 0, 1);
    add(0, 0, 0, 0, 10, 0, 0, 1);
    add(0, 0, 0, 0, 10, 0, 0, 1);
    add(0, 0, 0, 1, 11, 0, 0, 1);
    add(0, 0, 0, 1, 12, 1, 0, 1);
    add(0, 0, 0, 0, 12, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // three words back to back with ready low: third is dropped
    add(0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 1, 0, 1, 0, 0, 2);
    dc_fill = 1;
    add(0, 1, 2, 0, 1, 0, 1, 2);
    add(0, 0, 0, 0, 1, 0, 0, 2);
    add(0, 0, 0, 1, 2, 0, 0, 2);
    add(0, 0, 0, 1, 3, 0, 0, 2);
    add(0, 0, 0, 1, 4, 1, 0, 2);
    add(0, 0, 0, 1, 5, 0, 0, 1);
    add(0, 0, 0, 1, 6, 0, 0, 1);
    add(0, 0, 0, 1, 7, 0, 0, 1);
    add(0, 0, 0, 1, 8, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // full FIFO, write in the retire cycle is accepted
    add(0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 1, 0, 1, 0, 0, 2);
    add(0, 0, 0, 1, 2, 0, 0, 2);
    add(0, 0, 0, 1, 3, 0, 0, 2);
    add(0, 0, 0, 1, 4, 1, 0, 2);
    add(0, 1, 2, 1, 5, 0, 0, 2);
    add(0, 0, 0, 0, 5, 0, 0, 2);
    add(0, 0, 0, 1, 6, 0, 0, 2);
    add(0, 0, 0, 1, 7, 0, 0, 2);
    add(0, 0, 0, 1, 8, 1, 0, 2);
    add(0, 0, 0, 1, 9, 0, 0, 1);
    add(0, 0, 0, 1, 10, 0, 0, 1);
    add(0, 0, 0, 1, 11, 0, 0, 1);
    add(0, 0, 0, 1, 12, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // reset while lane 2 is presented
    add(0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 2, 0, 0, 1);
    add(0, 0, 0, 1, 3, 0, 0, 1);
    dc_fill = 0;
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 5, 0, 0, 1);
    add(0, 0, 0, 1, 6, 0, 0, 1);
    add(0, 0, 0, 1, 7, 0, 0, 1);
    add(0, 0, 0, 1, 8, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      reset            = tbl[i].rst;
      bus.packed_valid = tbl[i].pv;
      bus.packed_data  = mk_word(tbl[i].w);
      bus.point_ready  = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d valid", i), 128'(bus.point_valid), 128'(tbl[i].ept != 0));
      chk($sformatf("row%0d data", i), bus.point_data, pat(tbl[i].ept));
      chk($sformatf("row%0d last", i), 128'(bus.point_last), 128'(tbl[i].el));
      chk($sformatf("row%0d overflow", i), 128'(bus.overflow), 128'(tbl[i].eo));
      chk($sformatf("row%0d level", i), 128'(bus.fifo_level), 128'(tbl[i].elvl));
`ifdef UNPACK_DROP_CNT_EN
      chk($sformatf("row%0d drop_count", i), 128'(drop_count), 128'(tbl[i].edc));
`endif
    end

    // random traffic against the word-queue model
    model_step(1'b1, 1'b0, '0, 1'b0);
    reset = 1'b1;
    bus.packed_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      case ((c / 500) % 4)
        0:       pv_pct = 20;
        1:       pv_pct = 45;
        2:       pv_pct = 80;
        default: pv_pct = 30;
      endcase
      rrst = ($urandom_range(0, 299) == 0);
      rpv  = ($urandom_range(0, 99) < pv_pct);
      rrdy = ($urandom_range(0, 99) < 65);
      for (int j = 0; j < WW / 32; j++) rw[j*32 +: 32] = $urandom();
      reset            = rrst;
      bus.packed_valid = rpv;
      bus.packed_data  = rw;
      bus.point_ready  = rrdy;
      model_step(rrst, rpv, rw, rrdy);
      @(negedge clk);
      edata = '0;
      if (mq.size() > 0) begin
        hw    = mq[0];
        edata = hw[midx*PW +: PW];
      end
      chk($sformatf("rnd%0d valid", c), 128'(bus.point_valid), 128'(mq.size() > 0));
      chk($sformatf("rnd%0d data", c), bus.point_data, edata);
      chk($sformatf("rnd%0d last", c), 128'(bus.point_last),
          128'((mq.size() > 0) && (midx == P - 1)));
      chk($sformatf("rnd%0d overflow", c), 128'(bus.overflow), 128'(movf));
      chk($sformatf("rnd%0d level", c), 128'(bus.fifo_level), 128'(mq.size()));
`ifdef UNPACK_DROP_CNT_EN
      chk($sformatf("rnd%0d drop_count", c), 128'(drop_count), 128'(mdc));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
